// File: rtl/fwd_pkg.sv
// Shared types and default sizing for the operand-forwarding unit.
// A slot entry mirrors one in-flight register write as it moves down the pipeline.
package fwd_pkg;
  localparam int FWD_DATA_W   = 64;
  localparam int FWD_REG_AW   = 5;
  localparam int FWD_DEPTH    = 3;
  localparam int FWD_ZERO_REG = 31;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [FWD_REG_AW-1:0] rd;
    logic                  ready;
    logic [FWD_DATA_W-1:0] data;
  } fwd_entry_t;
endpackage

// File: rtl/fwd_port_select.sv
// One read port's youngest-match lookup over the in-flight slots; purely combinational.
// An unready youngest match raises stall and blocks any older ready match.
module fwd_port_select
  import fwd_pkg::*;
#(
  parameter int DEPTH    = FWD_DEPTH,
  parameter int REG_AW   = FWD_REG_AW,
  parameter int DATA_W   = FWD_DATA_W,
  parameter int ZERO_REG = FWD_ZERO_REG
) (
  input  fwd_entry_t [DEPTH-1:0] slots,
  input  logic [REG_AW-1:0]      rs_addr,
  input  logic [DATA_W-1:0]      rf_data,
  output logic [DATA_W-1:0]      fwd_data,
  output logic                   fwd_hit,
  output logic                   stall
);

  logic found;

  always_comb begin
    fwd_data = rf_data;
    fwd_hit  = 1'b0;
    stall    = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && slots[i].valid && slots[i].we && (slots[i].rd == rs_addr) &&
          (rs_addr != REG_AW'(ZERO_REG))) begin
        found = 1'b1;
        if (slots[i].ready) begin
          fwd_data = slots[i].data;
          fwd_hit  = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_bypass_unit.sv
// Operand forwarding: DEPTH-slot shift register of in-flight writes, zero-latency lookup per port.
// Stalls a port when its youngest producer is a load still waiting on memory data.
module fwd_bypass_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W   = FWD_DATA_W,
  parameter int REG_AW   = FWD_REG_AW,
  parameter int NUM_RD   = 2,
  parameter int DEPTH    = FWD_DEPTH,
  parameter int MEM_SLOT = 1,
  parameter int ZERO_REG = FWD_ZERO_REG
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       advance,
  input  logic                       issue_valid,
  input  logic                       issue_we,
  input  logic [REG_AW-1:0]          issue_rd,
  input  logic                       issue_is_load,
  input  logic [DATA_W-1:0]          ex_result,
  input  logic                       mem_load_valid,
  input  logic [DATA_W-1:0]          mem_load_data,
  input  logic                       flush,
  input  logic [NUM_RD*REG_AW-1:0]   rs_addr,
  input  logic [NUM_RD*DATA_W-1:0]   rf_data,
  output logic [NUM_RD*DATA_W-1:0]   fwd_data,
  output logic [NUM_RD-1:0]          fwd_hit,
  output logic [NUM_RD-1:0]          stall,
  output logic [$clog2(DEPTH+1)-1:0] inflight_cnt
);

  localparam int CNT_W = $clog2(DEPTH+1);

  fwd_entry_t [DEPTH-1:0] slots;
  fwd_entry_t [DEPTH-1:0] comp;
  fwd_entry_t [DEPTH-1:0] slots_nxt;
  logic [CNT_W-1:0]       cnt_nxt;

  always_comb begin
    // Load data completes in place first, so a same-edge advance carries it forward.
    comp = slots;
    if (mem_load_valid && slots[MEM_SLOT].valid && !slots[MEM_SLOT].ready) begin
      comp[MEM_SLOT].ready = 1'b1;
      comp[MEM_SLOT].data  = mem_load_data;
    end

    slots_nxt = comp;
    if (advance) begin
      for (int i = DEPTH-1; i > 0; i--) begin
        slots_nxt[i] = comp[i-1];
      end
      slots_nxt[0].valid = issue_valid;
      slots_nxt[0].we    = issue_we;
      slots_nxt[0].rd    = issue_rd;
      slots_nxt[0].ready = ~issue_is_load;
      slots_nxt[0].data  = issue_is_load ? '0 : ex_result;
    end
    if (flush) begin
      slots_nxt[0].valid = 1'b0;
    end

    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(slots_nxt[i].valid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slots        <= '0;
      inflight_cnt <= '0;
    end else begin
      slots        <= slots_nxt;
      inflight_cnt <= cnt_nxt;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    fwd_port_select #(
      .DEPTH    (DEPTH),
      .REG_AW   (REG_AW),
      .DATA_W   (DATA_W),
      .ZERO_REG (ZERO_REG)
    ) u_sel (
      .slots    (slots),
      .rs_addr  (rs_addr[p*REG_AW +: REG_AW]),
      .rf_data  (rf_data[p*DATA_W +: DATA_W]),
      .fwd_data (fwd_data[p*DATA_W +: DATA_W]),
      .fwd_hit  (fwd_hit[p]),
      .stall    (stall[p])
    );
  end

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// Directed table of per-cycle inputs and hand-computed outputs, plus a back-to-back load sequence.
module tb_fwd_bypass_unit;
  logic         clk = 1'b0;
  logic         reset, advance, issue_valid, issue_we, issue_is_load;
  logic [4:0]   issue_rd;
  logic [63:0]  ex_result, mem_load_data;
  logic         mem_load_valid, flush;
  logic [9:0]   rs_addr;
  logic [127:0] rf_data, fwd_data;
  logic [1:0]   fwd_hit, stall, inflight_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_bypass_unit dut (
    .clk(clk), .reset(reset), .advance(advance), .issue_valid(issue_valid),
    .issue_we(issue_we), .issue_rd(issue_rd), .issue_is_load(issue_is_load),
    .ex_result(ex_result), .mem_load_valid(mem_load_valid), .mem_load_data(mem_load_data),
    .flush(flush), .rs_addr(rs_addr), .rf_data(rf_data), .fwd_data(fwd_data),
    .fwd_hit(fwd_hit), .stall(stall), .inflight_cnt(inflight_cnt)
  );

  typedef struct {
    bit rst, adv, iv, we, ld, mlv, fl;
    logic [4:0]  rd, rs0, rs1;
    logic [63:0] ex, mld, rf0, rf1, d0, d1;
    logic [1:0]  hit, stl, cnt;
  } vec_t;

  function automatic vec_t mk(input bit rst, adv, iv, we, input int rd, input bit ld,
                              input logic [63:0] ex, input bit mlv, input logic [63:0] mld,
                              input bit fl, input int rs0, rs1, input logic [63:0] rf0, rf1,
                              d0, d1, input int hit, stl, cnt);
    vec_t v;
    v.rst = rst; v.adv = adv; v.iv = iv; v.we = we; v.rd = 5'(rd); v.ld = ld;
    v.ex = ex; v.mlv = mlv; v.mld = mld; v.fl = fl;
    v.rs0 = 5'(rs0); v.rs1 = 5'(rs1); v.rf0 = rf0; v.rf1 = rf1;
    v.d0 = d0; v.d1 = d1; v.hit = 2'(hit); v.stl = 2'(stl); v.cnt = 2'(cnt);
    return v;
  endfunction

  // Drive one cycle's inputs, check outputs for the current state, then take the edge.
  task automatic apply(input string nm, input vec_t v);
    reset = v.rst; advance = v.adv; issue_valid = v.iv; issue_we = v.we;
    issue_rd = v.rd; issue_is_load = v.ld; ex_result = v.ex;
    mem_load_valid = v.mlv; mem_load_data = v.mld; flush = v.fl;
    rs_addr = {v.rs1, v.rs0}; rf_data = {v.rf1, v.rf0};
    #2;
    n_vec++;
    if (fwd_data[63:0] !== v.d0 || fwd_data[127:64] !== v.d1 || fwd_hit !== v.hit ||
        stall !== v.stl || inflight_cnt !== v.cnt) begin
      n_err++;
      $display("FAIL %s: got fwd0=%h fwd1=%h hit=%b stall=%b cnt=%0d, want fwd0=%h fwd1=%h hit=%b stall=%b cnt=%0d",
               nm, fwd_data[63:0], fwd_data[127:64], fwd_hit, stall, inflight_cnt,
               v.d0, v.d1, v.hit, v.stl, v.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //              rst adv iv we rd ld ex        mlv mld       fl rs0 rs1 rf0     rf1     d0       d1      hit stl cnt
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0,        0, 0,        0,  3,  3, 'hAA,  'hAA,  'hAA,    'hAA,   0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1,  5, 0, 'h1234,   0, 0,        0,  5,  3, 'h55,  'h66,  'h55,    'h66,   0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0,        0, 0,        0,  5,  3, 'h55,  'h66,  'h1234,  'h66,   1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0,        0, 0,        0,  5,  3, 'h55,  'h66,  'h1234,  'h66,   1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0,        0, 0,        0,  5,  3, 'h55,  'h66,  'h1234,  'h66,   1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,        0,  5,  3, 'h55,  'h66,  'h55,    'h66,   0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0,  5, 0, 'hBAD,    0, 0,        0,  5,  3, 'h55,  'h66,  'h55,    'h66,   0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,        1,  5,  3, 'h55,  'h66,  'h55,    'h66,   0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1,  7, 0, 'h11,     0, 0,        0,  7,  7, 0,     0,     0,       0,      0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1,  7, 0, 'h22,     0, 0,        0,  7,  7, 0,     0,     'h11,    'h11,   3, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,        0,  7,  7, 0,     0,     'h22,    'h22,   3, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0,        0, 0,        0,  7,  7, 0,     0,     'h22,    'h22,   3, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0,        0, 0,        0,  7,  7, 0,     0,     'h22,    'h22,   3, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0,        0, 0,        0,  7,  7, 0,     0,     'h22,    'h22,   3, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1,  9, 1, 'h999,    0, 0,        0,  9,  7, 'h90,  'h70,  'h90,    'h70,   0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0,        1, 'hDEAD,   0,  9,  7, 'h90,  'h70,  'h90,    'h70,   0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,        0,  9,  7, 'h90,  'h70,  'h90,    'h70,   0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0,        1, 'hBEEF,   0,  9,  7, 'h90,  'h70,  'h90,    'h70,   0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,        1, 'h1111,   0,  9,  7, 'h90,  'h70,  'hBEEF,  'h70,   1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0,        0, 0,        0,  9,  7, 'h90,  'h70,  'hBEEF,  'h70,   1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1,  9, 0, 'h77,     0, 0,        0,  9,  7, 'h90,  'h70,  'h90,    'h70,   0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1,  9, 1, 0,        0, 0,        0,  9,  7, 'h90,  'h70,  'h77,    'h70,   1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,        1, 'hCAFE,   0,  9,  7, 'h90,  'h70,  'h90,    'h70,   0, 1, 2));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0,        0, 0,        0,  9,  7, 'h90,  'h70,  'h90,    'h70,   0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,        0,  9,  7, 'h90,  'h70,  'h90,    'h70,   0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,        1, 'h5555,   0,  9,  7, 'h90,  'h70,  'h90,    'h70,   0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,        0,  9,  7, 'h90,  'h70,  'h5555,  'h70,   1, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0,        0, 0,        0,  9,  7, 'h90,  'h70,  'h5555,  'h70,   1, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0,        0, 0,        0,  9,  7, 'h90,  'h70,  'h5555,  'h70,   1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 31, 0, 'hFF,     0, 0,        0, 31, 31, 0,     'h3,   0,       'h3,    0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,        0, 31, 31, 0,     'h3,   0,       'h3,    0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 31, 1, 0,        0, 0,        0, 31, 31, 0,     'h3,   0,       'h3,    0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,        0, 31, 31, 0,     'h3,   0,       'h3,    0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,        1, 31, 31, 0,     'h3,   0,       'h3,    0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0,        0, 0,        0, 31, 31, 0,     'h3,   0,       'h3,    0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0,        0, 0,        0, 31, 31, 0,     'h3,   0,       'h3,    0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1,  8, 0, 'h88,     0, 0,        0,  4,  8, 'h40,  'h41,  'h40,    'h41,   0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1,  4, 0, 'h44,     0, 0,        1,  4,  8, 'h40,  'h41,  'h40,    'h88,   2, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,        0,  4,  8, 'h40,  'h41,  'h40,    'h88,   2, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1,  4, 0, 'h44,     0, 0,        0,  4,  8, 'h40,  'h41,  'h40,    'h88,   2, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,        1,  4,  8, 'h40,  'h41,  'h44,    'h88,   3, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,        0,  4,  8, 'h40,  'h41,  'h40,    'h88,   2, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0,        0, 0,        0,  4,  8, 'h40,  'h41,  'h40,    'h88,   2, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1,  9, 1, 0,        0, 0,        0,  9,  9, 'h90,  'h91,  'h90,    'h91,   0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1,  9, 1, 0,        1, 'h77,     0,  9,  9, 'h90,  'h91,  'h90,    'h91,   0, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0,        0, 0,        0,  9,  9, 'h90,  'h91,  'h90,    'h91,   0, 0, 0));

    reset = 1'b1; advance = 1'b0; issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0;
    issue_is_load = 1'b0; ex_result = '0; mem_load_valid = 1'b0; mem_load_data = '0;
    flush = 1'b0; rs_addr = '0; rf_data = '0;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // Two loads to r10: the older completes first, the younger must keep both ports stalled.
    apply("ld2_issue_a",    mk(0, 1, 1, 1, 10, 1, 0, 0, 0,      0, 10, 10, 'hA, 'hB, 'hA,  'hB,  0, 0, 0));
    apply("ld2_issue_b",    mk(0, 1, 1, 1, 10, 1, 0, 0, 0,      0, 10, 10, 'hA, 'hB, 'hA,  'hB,  0, 3, 1));
    apply("ld2_complete_a", mk(0, 0, 0, 0,  0, 0, 0, 1, 'hA0,   0, 10, 10, 'hA, 'hB, 'hA,  'hB,  0, 3, 2));
    apply("ld2_young_stall",mk(0, 0, 0, 0,  0, 0, 0, 0, 0,      0, 10, 10, 'hA, 'hB, 'hA,  'hB,  0, 3, 2));
    apply("ld2_ready_ign",  mk(0, 1, 0, 0,  0, 0, 0, 1, 'hB0,   0, 10, 10, 'hA, 'hB, 'hA,  'hB,  0, 3, 2));
    apply("ld2_b_in_mem",   mk(0, 0, 0, 0,  0, 0, 0, 0, 0,      0, 10, 10, 'hA, 'hB, 'hA,  'hB,  0, 3, 2));
    apply("ld2_complete_b", mk(0, 0, 0, 0,  0, 0, 0, 1, 'hB0,   0, 10, 10, 'hA, 'hB, 'hA,  'hB,  0, 3, 2));
    apply("ld2_fwd_b",      mk(0, 0, 0, 0,  0, 0, 0, 0, 0,      0, 10, 10, 'hA, 'hB, 'hB0, 'hB0, 3, 0, 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
